// File: rtl/prediction_pkg.sv
// prediction_pkg: shared types and elaboration helpers for prediction_seq.
//   state_t        FSM state encoding (IDLE, ACCUM, DONE)
//   calc_n_beats   number of accumulation beats, ceil(n_neurons/lanes)
//   min_acc_width  smallest accumulator width that cannot overflow
//   X_POS / X_NEG  nominal neuron-state encodings (+1 / -1)
package prediction_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] X_POS = 2'b01;
  localparam logic [1:0] X_NEG = 2'b11;

  function automatic int calc_n_beats(input int n_neurons, input int lanes);
    return (n_neurons + lanes - 1) / lanes;
  endfunction

  function automatic int min_acc_width(input int w_width, input int x_width,
                                       input int n_neurons);
    return w_width + x_width + $clog2(n_neurons);
  endfunction

endpackage

// File: rtl/prediction_mac_lanes.sv
// prediction_mac_lanes: combinational multiply/add of one beat of lanes.
//   weights    LANES packed signed weights, lane l at [W_WIDTH*l +: W_WIDTH]
//   states     LANES packed signed neuron states, lane l at [X_WIDTH*l +: X_WIDTH]
//   lane_mask  per-lane enable; a masked lane contributes zero
//   sum        signed ACC_WIDTH sum of the enabled lane products
module prediction_mac_lanes
  import prediction_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int W_WIDTH   = 10,
  parameter int X_WIDTH   = 2,
  parameter int ACC_WIDTH = 18
) (
  input  logic [LANES*W_WIDTH-1:0]  weights,
  input  logic [LANES*X_WIDTH-1:0]  states,
  input  logic [LANES-1:0]          lane_mask,
  output logic signed [ACC_WIDTH-1:0] sum
);

  localparam int P_WIDTH = W_WIDTH + X_WIDTH;

  logic signed [P_WIDTH-1:0] prod [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [W_WIDTH-1:0] w;
    logic signed [X_WIDTH-1:0] x;
    assign w = weights[W_WIDTH*l +: W_WIDTH];
    assign x = states[X_WIDTH*l +: X_WIDTH];
    // Both operands are sign-extended to the full product width first.
    assign prod[l] = lane_mask[l] ? P_WIDTH'(w) * P_WIDTH'(x) : '0;
  end

  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) begin
      sum = sum + ACC_WIDTH'(prod[l]);
    end
  end

endmodule

// File: rtl/prediction_seq.sv
// prediction_seq: sequential weighted-sum predictor. Captures a weight vector
// and a neuron-state vector, accumulates LANES products per cycle, then
// presents the narrowed sum y and its sign activation x_new.
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       operand handshake
//   weights_packed            N_NEURONS signed weights
//   xalt_packed               N_NEURONS signed neuron states
//   out_valid / out_ready     result handshake
//   y                         weighted sum narrowed to OUT_WIDTH
//   x_new                     +1 if full sum >= 0, else -1
//   sat_flag                  only with PREDICTION_SAT_EN: y was clamped
// Optional feature macro: PREDICTION_SAT_EN (saturating y plus sat_flag).
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// ACCUM | adding one beat of LANES products per cycle
// DONE  | result held on y/x_new with out_valid high until out_ready
module prediction_seq
  import prediction_pkg::*;
#(
  parameter int N_NEURONS = 20,
  parameter int W_WIDTH   = 10,
  parameter int X_WIDTH   = 2,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 18,
  parameter int OUT_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_NEURONS*W_WIDTH-1:0] weights_packed,
  input  logic [N_NEURONS*X_WIDTH-1:0] xalt_packed,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         y,
  output logic [X_WIDTH-1:0]           x_new
`ifdef PREDICTION_SAT_EN
  ,
  output logic                         sat_flag
`endif
);

  localparam int N_BEATS = calc_n_beats(N_NEURONS, LANES);
  localparam int PAD     = N_BEATS * LANES - N_NEURONS;
  localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(N_BEATS - 1);
  localparam logic [X_WIDTH-1:0] X_ONE     = X_WIDTH'(X_POS);
  localparam logic [X_WIDTH-1:0] X_MINUS   = X_WIDTH'($signed(X_NEG));

  if (ACC_WIDTH < min_acc_width(W_WIDTH, X_WIDTH, N_NEURONS)) begin : g_acc_check
    $error("prediction_seq: ACC_WIDTH too small for the worst-case sum");
  end

  state_t                          state;
  logic [CNT_W-1:0]                beat;
  logic signed [ACC_WIDTH-1:0]     acc;
  logic [N_NEURONS*W_WIDTH-1:0]    w_reg;
  logic [N_NEURONS*X_WIDTH-1:0]    x_reg;

  // Operands padded to a whole number of beats so every beat slice is in range.
  logic [N_BEATS*LANES*W_WIDTH-1:0] w_pad;
  logic [N_BEATS*LANES*X_WIDTH-1:0] x_pad;

  if (PAD > 0) begin : g_pad
    assign w_pad = {{(PAD*W_WIDTH){1'b0}}, w_reg};
    assign x_pad = {{(PAD*X_WIDTH){1'b0}}, x_reg};
  end else begin : g_nopad
    assign w_pad = w_reg;
    assign x_pad = x_reg;
  end

  logic [LANES*W_WIDTH-1:0]    lane_w;
  logic [LANES*X_WIDTH-1:0]    lane_x;
  logic [LANES-1:0]            lane_mask;
  logic signed [ACC_WIDTH-1:0] lane_sum;
  logic signed [ACC_WIDTH-1:0] next_acc;
  logic [OUT_WIDTH-1:0]        y_next;

  always_comb begin
    lane_w = '0;
    lane_x = '0;
    for (int b = 0; b < N_BEATS; b++) begin
      if (beat == CNT_W'(b)) begin
        lane_w = w_pad[b*LANES*W_WIDTH +: LANES*W_WIDTH];
        lane_x = x_pad[b*LANES*X_WIDTH +: LANES*X_WIDTH];
      end
    end
    for (int l = 0; l < LANES; l++) begin
      lane_mask[l] = (int'(beat) * LANES + l) < N_NEURONS;
    end
  end

  prediction_mac_lanes #(
    .LANES    (LANES),
    .W_WIDTH  (W_WIDTH),
    .X_WIDTH  (X_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .weights  (lane_w),
    .states   (lane_x),
    .lane_mask(lane_mask),
    .sum      (lane_sum)
  );

  assign next_acc = acc + lane_sum;

`ifdef PREDICTION_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] Y_MAX = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN = ~Y_MAX;
  logic sat_next;

  always_comb begin
    sat_next = 1'b1;
    if (next_acc > Y_MAX)      y_next = Y_MAX[OUT_WIDTH-1:0];
    else if (next_acc < Y_MIN) y_next = Y_MIN[OUT_WIDTH-1:0];
    else begin
      y_next   = next_acc[OUT_WIDTH-1:0];
      sat_next = 1'b0;
    end
  end
`else
  assign y_next = next_acc[OUT_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      x_new     <= '0;
      beat      <= '0;
      acc       <= '0;
      w_reg     <= '0;
      x_reg     <= '0;
`ifdef PREDICTION_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w_reg    <= weights_packed;
            x_reg    <= xalt_packed;
            acc      <= '0;
            beat     <= '0;
            in_ready <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc  <= next_acc;
          beat <= beat + CNT_W'(1);
          if (beat == LAST_BEAT) begin
            y         <= y_next;
            // Activation follows the full-width sign, not the narrowed y.
            x_new     <= next_acc[ACC_WIDTH-1] ? X_MINUS : X_ONE;
`ifdef PREDICTION_SAT_EN
            sat_flag  <= sat_next;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prediction_seq.sv
module tb_prediction_seq;
  localparam int N = 20, W = 10, X = 2, L = 4, A = 18, O = 10;
  localparam int N7 = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
  logic [N*W-1:0] weights = '0;
  logic [N*X-1:0] xs = '0;
  logic [O-1:0] y;
  logic [X-1:0] x_new;

  logic in_valid7 = 1'b0, out_ready7 = 1'b0, in_ready7, out_valid7;
  logic [N7*W-1:0] weights7 = '0;
  logic [N7*X-1:0] xs7 = '0;
  logic [O-1:0] y7;
  logic [X-1:0] x_new7;
`ifdef PREDICTION_SAT_EN
  logic sat_flag, sat_flag7;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail = 0;
  int accept_cyc = 0;

  typedef struct {
    logic [O-1:0] y;
    logic [X-1:0] x;
    logic         sat;
  } exp_t;

  exp_t sb[$];
  exp_t sb7[$];
  exp_t mon_e, mon_e7;

  prediction_seq #(.N_NEURONS(N), .W_WIDTH(W), .X_WIDTH(X), .LANES(L),
                   .ACC_WIDTH(A), .OUT_WIDTH(O)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .weights_packed(weights), .xalt_packed(xs),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .x_new(x_new)
`ifdef PREDICTION_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  prediction_seq #(.N_NEURONS(N7), .W_WIDTH(W), .X_WIDTH(X), .LANES(L),
                   .ACC_WIDTH(A), .OUT_WIDTH(O)) dut7 (
    .clk(clk), .rst(rst), .in_valid(in_valid7), .in_ready(in_ready7),
    .weights_packed(weights7), .xalt_packed(xs7),
    .out_valid(out_valid7), .out_ready(out_ready7), .y(y7), .x_new(x_new7)
`ifdef PREDICTION_SAT_EN
    , .sat_flag(sat_flag7)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: a result is consumed at the edge after valid&ready.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected: got result y=%0h with empty queue", y);
      end else begin
        mon_e = sb.pop_front();
        check("sb_y", 32'(y), 32'(mon_e.y));
        check("sb_x_new", 32'(x_new), 32'(mon_e.x));
`ifdef PREDICTION_SAT_EN
        check("sb_sat_flag", 32'(sat_flag), 32'(mon_e.sat));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid7 === 1'b1 && out_ready7 === 1'b1) begin
      if (sb7.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb7_unexpected: got result y=%0h with empty queue", y7);
      end else begin
        mon_e7 = sb7.pop_front();
        check("sb7_y", 32'(y7), 32'(mon_e7.y));
        check("sb7_x_new", 32'(x_new7), 32'(mon_e7.x));
`ifdef PREDICTION_SAT_EN
        check("sb7_sat_flag", 32'(sat_flag7), 32'(mon_e7.sat));
`endif
      end
    end
  end

  task automatic set_all(input logic [W-1:0] wv, input logic [X-1:0] xv);
    for (int j = 0; j < N; j++) begin
      weights[j*W +: W] = wv;
      xs[j*X +: X] = xv;
    end
  endtask

  task automatic push(input logic [O-1:0] ey, input logic [X-1:0] ex, input logic es);
    exp_t e;
    e.y = ey; e.x = ex; e.sat = es;
    sb.push_back(e);
  endtask

  task automatic issue();
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("issue_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    accept_cyc = cyc;
    // Operands may change freely once accepted.
    weights = ~weights;
    xs = ~xs;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [O-1:0] ey, input logic [X-1:0] ex, input logic es);
    int lat;
    push(ey, ex, es);
    issue();
    wait_valid(lat);
    check("latency", 32'(lat), 32'd5);
    release_result();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, c0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_x_new", 32'(x_new), 32'd0);
    rst = 1'b0;

    // all ones -> 20
    set_all(10'd1, 2'b01);
    run_op(10'd20, 2'b01, 1'b0);

    // 20*511 = 10220: wraps to -20 or clamps to 511
    set_all(10'd511, 2'b01);
`ifdef PREDICTION_SAT_EN
    run_op(10'd511, 2'b01, 1'b1);
`else
    run_op(10'h3EC, 2'b01, 1'b0);
`endif

    // backpressure: result 40 held for 3 cycles
    set_all(10'd2, 2'b01);
    push(10'd40, 2'b01, 1'b0);
    issue();
    c0 = accept_cyc;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd5);
    repeat (3) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_y", 32'(y), 32'd40);
      check("bp_x_new", 32'(x_new), 32'd1);
      @(posedge clk); #1;
    end
    release_result();
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    // all x=-1 -> -20
    set_all(10'd1, 2'b11);
    push(10'h3EC, 2'b11, 1'b0);
    issue();
    check("bp_period", 32'(accept_cyc - c0), 32'd10);
    c0 = accept_cyc;
    wait_valid(lat);
    check("latency2", 32'(lat), 32'd5);
    release_result();
    set_all(10'd1, 2'b01);
    push(10'd20, 2'b01, 1'b0);
    issue();
    check("issue_period", 32'(accept_cyc - c0), 32'd7);
    wait_valid(lat);
    release_result();

    // reset mid-ACCUM discards the operation
    set_all(10'd7, 2'b01);
    issue();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_y", 32'(y), 32'd0);
    repeat (8) begin
      @(posedge clk); #1;
      check("abort_stays_idle", 32'(out_valid), 32'd0);
    end
    set_all(10'h3FD, 2'b01);
    run_op(10'h3C4, 2'b11, 1'b0);

    // exact zero resolves to +1
    set_all(10'd0, 2'b01);
    weights[0*W +: W] = 10'd5; weights[1*W +: W] = 10'd5;
    xs[1*X +: X] = 2'b11;
    run_op(10'd0, 2'b01, 1'b0);
    // x=10 with weight 3 contributes -6
    set_all(10'd0, 2'b01);
    weights[0*W +: W] = 10'd5; weights[1*W +: W] = 10'd5; weights[2*W +: W] = 10'd3;
    xs[1*X +: X] = 2'b11; xs[2*X +: X] = 2'b10;
    run_op(10'h3FA, 2'b11, 1'b0);
    // x=00 contributes nothing
    set_all(10'd4, 2'b00);
    xs[0*X +: X] = 2'b01;
    run_op(10'd4, 2'b01, 1'b0);

    // N=7, LANES=4: weights 1..7, x +1,-1,... -> 4 over 2 beats
    begin
      exp_t e;
      for (int j = 0; j < N7; j++) begin
        weights7[j*W +: W] = W'(j + 1);
        xs7[j*X +: X] = (j % 2 == 0) ? 2'b01 : 2'b11;
      end
      e.y = 10'd4; e.x = 2'b01; e.sat = 1'b0;
      sb7.push_back(e);
      check("n7_in_ready", 32'(in_ready7), 32'd1);
      in_valid7 = 1'b1;
      @(posedge clk); #1;
      in_valid7 = 1'b0;
      weights7 = ~weights7;
      xs7 = ~xs7;
      lat = 0;
      while (out_valid7 !== 1'b1 && lat < 30) begin
        @(posedge clk); #1; lat++;
      end
      check("n7_latency", 32'(lat), 32'd2);
      out_ready7 = 1'b1;
      @(posedge clk); #1;
      out_ready7 = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("sb7_drained", 32'(sb7.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
